// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 32-byte lines.
// Hits complete combinationally in IDLE; misses run WRITEBACK (if dirty) then FILL.
module l1_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 2 ** S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t              state_r;
  logic [SETS-1:0]     valid_r;
  logic [SETS-1:0]     dirty_r;
  logic [TAG_W-1:0]    tag_arr [SETS];
  logic [255:0]        data_arr [SETS];
  logic [TAG_W-1:0]    miss_tag_r;
  logic [S_INDEX-1:0]  miss_idx_r;
  logic                pmem_read_r;
  logic                pmem_write_r;

  logic [TAG_W-1:0]    req_tag_s;
  logic [S_INDEX-1:0]  req_idx_s;
  logic [2:0]          req_word_s;
  logic                req_s;
  logic                hit_s;
  logic                write_hit_s;
  logic [255:0]        line_s;
  logic [31:0]         word_s;
  logic                unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  assign req_tag_s        = mem_address[31:5+S_INDEX];
  assign req_idx_s        = mem_address[4+S_INDEX:5];
  assign req_word_s       = mem_address[4:2];
  assign req_s            = mem_read | mem_write;
  assign line_s           = data_arr[req_idx_s];
  assign word_s           = line_s[{req_word_s, 5'b0} +: 32];
  assign unused_addr_bits = ^mem_address[1:0];
  assign pmem_read        = pmem_read_r;
  assign pmem_write       = pmem_write_r;
  assign pmem_wdata       = data_arr[miss_idx_r];

  // Hit detection and CPU response; only IDLE may answer the CPU.
  always_comb begin
    hit_s       = 1'b0;
    write_hit_s = 1'b0;
    mem_resp    = 1'b0;
    mem_rdata   = 32'h0;
    if (state_r == IDLE && req_s && valid_r[req_idx_s] &&
        tag_arr[req_idx_s] == req_tag_s) begin
      hit_s       = 1'b1;
      write_hit_s = mem_write;
      mem_resp    = 1'b1;
      mem_rdata   = word_s;
    end else begin
      hit_s       = 1'b0;
      write_hit_s = 1'b0;
    end
  end

  // Line address presented to memory: victim line in WRITEBACK, missed line in FILL.
  always_comb begin
    pmem_address = 32'h0;
    case (state_r)
      WRITEBACK: pmem_address = {tag_arr[miss_idx_r], miss_idx_r, 5'b0};
      FILL:      pmem_address = {miss_tag_r, miss_idx_r, 5'b0};
      default:   pmem_address = 32'h0;
    endcase
  end

  // Miss FSM with valid/dirty state and registered pmem strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      dirty_r      <= '0;
      miss_tag_r   <= '0;
      miss_idx_r   <= '0;
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && !hit_s) begin
            // The missed address is captured so a dropped request still fills coherently.
            miss_tag_r <= req_tag_s;
            miss_idx_r <= req_idx_s;
            if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
              state_r      <= WRITEBACK;
              pmem_write_r <= 1'b1;
            end else begin
              state_r     <= FILL;
              pmem_read_r <= 1'b1;
            end
          end else if (write_hit_s) begin
            dirty_r[req_idx_s] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty_r[miss_idx_r] <= 1'b0;
            pmem_write_r        <= 1'b0;
            pmem_read_r         <= 1'b1;
            state_r             <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid_r[miss_idx_r] <= 1'b1;
            dirty_r[miss_idx_r] <= 1'b0;
            pmem_read_r         <= 1'b0;
            state_r             <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          pmem_read_r  <= 1'b0;
          pmem_write_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays: line fill or byte-merged write hit.
  always_ff @(posedge clk) begin
    if (state_r == FILL && pmem_resp) begin
      data_arr[miss_idx_r] <= pmem_rdata;
      tag_arr[miss_idx_r]  <= miss_tag_r;
    end else if (write_hit_s) begin
      data_arr[req_idx_s][{req_word_s, 5'b0} +: 32] <=
        merge_bytes(word_s, mem_wdata, mem_byte_enable);
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache: directed steps plus random accesses checked against a
// flat word-memory reference and a per-set line-ownership model.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  l1_cache #(.S_INDEX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  logic [255:0] pmem_lines [logic [31:0]];
  logic [31:0]  ref_mem    [logic [31:0]];
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [31:0]  m_line  [8];

  int           n_wb = 0, n_fill = 0, busy = 0, pm_hold = 0;
  logic [31:0]  last_wb_addr, last_fill_addr;
  logic [255:0] last_wb_data;
  logic         t5_seen;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0044) return 32'hDEAD_BEEF;
    else if (a[31:5] == 27'h4) return 32'h0;
    else return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    logic [255:0] l;
    if (pmem_lines.exists(la)) return pmem_lines[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = get_line({wa[31:5], 5'b0});
    return l[{wa[4:2], 5'b0} +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Reset discards dirty data: the visible memory reverts to backing store.
  task automatic model_reset();
    logic [255:0] l;
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        l = get_line(m_line[s]);
        for (int k = 0; k < 8; k++) ref_mem[m_line[s] + 32'(4*k)] = l[32*k +: 32];
      end
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  // Physical memory responder with random latency.
  initial begin : responder
    int pm_cnt;
    int pm_lat;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    pm_cnt = 0;
    pm_lat = 0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (!rst_n) begin
        pm_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        busy++;
        check("strobe_excl", 256'(pmem_read & pmem_write), 256'(0));
        check("pmem_align", 256'(pmem_address[4:0]), 256'(0));
        check("no_resp_in_miss", 256'(mem_resp), 256'(0));
        if (pm_hold == 0 && pm_cnt >= pm_lat) begin
          if (pmem_write) begin
            n_wb++;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            pmem_lines[pmem_address] = pmem_wdata;
          end else begin
            n_fill++;
            last_fill_addr = pmem_address;
            pmem_rdata = get_line(pmem_address);
          end
          pmem_resp = 1'b1;
          pm_cnt = 0;
          pm_lat = $urandom_range(0, 2);
        end else begin
          pm_cnt++;
        end
      end else begin
        pm_cnt = 0;
      end
    end
  end

  task automatic access(input logic rd_en, input logic wr_en, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input string tag);
    int           wb0, fill0, cycles, set;
    logic         got, hit, exp_wb;
    logic [31:0]  rdata, la, exp_rd, exp_wb_addr;
    logic [255:0] exp_wb_line;
    la  = {a[31:5], 5'b0};
    set = int'(a[7:5]);
    hit = m_valid[set] && m_line[set] == la;
    exp_wb = !hit && m_valid[set] && m_dirty[set];
    exp_wb_addr = m_line[set];
    for (int k = 0; k < 8; k++) exp_wb_line[32*k +: 32] = ref_word(m_line[set] + 32'(4*k));
    if (!hit) begin
      m_valid[set] = 1'b1;
      m_line[set]  = la;
      m_dirty[set] = 1'b0;
    end
    if (wr_en) begin
      ref_mem[{a[31:2], 2'b00}] = merge(ref_word(a), wd, be);
      m_dirty[set] = 1'b1;
    end
    exp_rd = ref_word(a);

    @(posedge clk); #1;
    wb0 = n_wb; fill0 = n_fill; busy = 0;
    mem_read = rd_en; mem_write = wr_en; mem_address = a;
    mem_byte_enable = be; mem_wdata = wd;
    got = 1'b0; cycles = 0; rdata = 32'h0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1'b1;
        rdata = mem_rdata;
      end else begin
        cycles++;
      end
    end
    check({tag, " resp"}, 256'(got), 256'(1));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    if (got) begin
      if (!wr_en) check({tag, " rdata"}, 256'(rdata), 256'(exp_rd));
      check({tag, " latency"}, 256'(cycles), hit ? 256'(0) : 256'(1 + busy));
      check({tag, " wb_count"}, 256'(n_wb - wb0), 256'(exp_wb ? 1 : 0));
      check({tag, " fill_count"}, 256'(n_fill - fill0), 256'(hit ? 0 : 1));
      if (exp_wb) begin
        check({tag, " wb_addr"}, 256'(last_wb_addr), 256'(exp_wb_addr));
        check({tag, " wb_data"}, last_wb_data, exp_wb_line);
      end
      if (!hit) check({tag, " fill_addr"}, 256'(last_fill_addr), 256'(la));
    end
  endtask

  initial begin : main
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
    mem_address = 32'h0; mem_wdata = 32'h0;
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0; m_dirty[s] = 1'b0; m_line[s] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset mem_resp", 256'(mem_resp), 256'(0));
    check("reset pmem_read", 256'(pmem_read), 256'(0));
    check("reset pmem_write", 256'(pmem_write), 256'(0));
    @(negedge clk); rst_n = 1'b1;

    access(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, "t1 read miss");
    access(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, "t2 read hit");
    access(1'b0, 1'b1, 32'h0000_0044, 4'b0011, 32'h1234_5678, "t3 write hit");
    access(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, "t3 readback");
    check("t3 value", 256'(ref_word(32'h44)), 256'(32'hDEAD_5678));
    access(1'b1, 1'b0, 32'h0000_0144, 4'h0, 32'h0, "t4 dirty evict");

    // Reset in the middle of a fill.
    pm_hold = 1;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 32'h0000_0044; mem_byte_enable = 4'h0;
    t5_seen = 1'b0;
    for (int i = 0; i < 20 && !t5_seen; i++) begin
      @(negedge clk);
      if (pmem_read) t5_seen = 1'b1;
    end
    check("t5 fill started", 256'(t5_seen), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t5 pmem_read drop", 256'(pmem_read), 256'(0));
    check("t5 pmem_write low", 256'(pmem_write), 256'(0));
    check("t5 no mem_resp", 256'(mem_resp), 256'(0));
    mem_read = 1'b0;
    model_reset();
    @(posedge clk); #1;
    pm_hold = 0;
    @(negedge clk); rst_n = 1'b1;
    access(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, "t5 reread miss");

    access(1'b0, 1'b1, 32'h0000_0080, 4'b1000, 32'hAA00_0000, "t6 write miss");
    access(1'b1, 1'b0, 32'h0000_0080, 4'h0, 32'h0, "t6 readback");
    check("t6 value", 256'(ref_word(32'h80)), 256'(32'hAA00_0000));
    access(1'b1, 1'b1, 32'h0000_0088, 4'b0110, 32'h0BAD_F00D, "rd+wr as write");
    access(1'b1, 1'b0, 32'h0000_0088, 4'h0, 32'h0, "rd+wr readback");

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int          op;
      a  = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'b00};
      op = $urandom_range(0, 3);
      access(op != 2, op >= 2, a, 4'($urandom), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
